// File: rtl/twiddle_addr_sequencer.sv
// Twiddle ROM address sequencer for the radix-2 FFT datapath.
// Walks every stage and butterfly beat and drives the shared real/imag twiddle
// ROM address {stage, k}. It also tracks the ROM's one-cycle registered read
// and presents each twiddle to the butterfly unit with a valid/ready handshake.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; rom_addr parks on the last presented address
//   RUN   | issuing addresses and presenting twiddles to the butterfly unit
//   DONE  | one-cycle completion pulse after the final transfer
module twiddle_addr_sequencer #(
  parameter int NUM_STAGES     = 7,
  parameter int BFLY_PER_STAGE = 8,
  parameter int ADDR_W         = 5,
  parameter int K_W            = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  bfly_ready,
  output logic [ADDR_W-1:0]     rom_addr,
  output logic                  tw_valid,
  output logic [ADDR_W-1:0]     tw_addr,
  output logic [ADDR_W-K_W-1:0] tw_stage,
  output logic                  tw_last_in_stage,
  output logic                  tw_last,
  output logic                  busy,
  output logic                  done
);

  localparam int SW    = ADDR_W - K_W;
  localparam int CLOG2 = $clog2(BFLY_PER_STAGE);
  // The beat counter must be at least K_W wide so k can be sliced from it.
  localparam int CW    = (CLOG2 > K_W) ? CLOG2 : K_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SW-1:0]    stage_cnt;
  logic [CW-1:0]    bfly_cnt;
  logic             issued_all;

  logic             adv;
  logic             xfer;
  logic             issue;
  logic             clear;
  logic             bfly_end;
  logic             stage_end;
  logic [ADDR_W-1:0] issue_addr;

  assign adv        = !tw_valid || bfly_ready;
  assign xfer       = tw_valid && bfly_ready;
  assign bfly_end   = (bfly_cnt == CW'(BFLY_PER_STAGE - 1));
  assign stage_end  = (stage_cnt == SW'(NUM_STAGES - 1));
  assign issue_addr = {stage_cnt, bfly_cnt[K_W-1:0]};

  // A new address is issued only while running, not aborting, with the
  // presentation slot free or draining this cycle, and beats still pending.
  assign issue = (state_q == RUN) && !abort && adv && !issued_all;

  // Clearing happens on start acceptance from IDLE and on abort elsewhere.
  assign clear = ((state_q == IDLE) && start) || ((state_q != IDLE) && abort);

  // On a stall or outside RUN the ROM re-reads the presented address so its
  // registered output keeps holding the presented twiddle.
  assign rom_addr = issue ? issue_addr : tw_addr;

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides completion, start wins over abort in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (abort)                  state_d = IDLE;
        else if (xfer && tw_last)   state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Beat counters and the presented-twiddle register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_cnt        <= '0;
      bfly_cnt         <= '0;
      issued_all       <= 1'b0;
      tw_valid         <= 1'b0;
      tw_addr          <= '0;
      tw_stage         <= '0;
      tw_last_in_stage <= 1'b0;
      tw_last          <= 1'b0;
    end else if (clear) begin
      stage_cnt        <= '0;
      bfly_cnt         <= '0;
      issued_all       <= 1'b0;
      tw_valid         <= 1'b0;
      tw_addr          <= '0;
      tw_stage         <= '0;
      tw_last_in_stage <= 1'b0;
      tw_last          <= 1'b0;
    end else if (issue) begin
      tw_valid         <= 1'b1;
      tw_addr          <= issue_addr;
      tw_stage         <= stage_cnt;
      tw_last_in_stage <= bfly_end;
      tw_last          <= bfly_end && stage_end;
      if (bfly_end) begin
        bfly_cnt  <= '0;
        stage_cnt <= stage_cnt + SW'(1);
        if (stage_end) issued_all <= 1'b1;
      end else begin
        bfly_cnt <= bfly_cnt + CW'(1);
      end
    end else if ((state_q == RUN) && adv) begin
      // Slot drained with nothing left to issue.
      tw_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_twiddle_addr_sequencer.sv
// Self-checking bench for twiddle_addr_sequencer with a registered twiddle ROM
// model (Q8 cosine, angle step pi/2^stage) and a beat-level reference model.
module tb_twiddle_addr_sequencer;

  localparam int NS   = 7;
  localparam int BPS  = 8;
  localparam int TOT  = NS * BPS;
  localparam real PI  = 3.14159265358979323846;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        bfly_ready;
  logic [4:0]  rom_addr;
  logic        tw_valid;
  logic [4:0]  tw_addr;
  logic [2:0]  tw_stage;
  logic        tw_last_in_stage;
  logic        tw_last;
  logic        busy;
  logic        done;
  logic [15:0] rom_data;

  int checks;
  int failures;

  twiddle_addr_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .bfly_ready       (bfly_ready),
    .rom_addr         (rom_addr),
    .tw_valid         (tw_valid),
    .tw_addr          (tw_addr),
    .tw_stage         (tw_stage),
    .tw_last_in_stage (tw_last_in_stage),
    .tw_last          (tw_last),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_ref(input logic [4:0] a);
    int  s;
    int  k;
    real v;
    s = int'(a[4:2]);
    k = int'(a[1:0]);
    v = 256.0 * $cos(k * PI / (2.0 ** s));
    return 16'($rtoi(v));
  endfunction

  // Registered-read ROM shared by real/imag paths.
  always @(posedge clk) rom_data <= rom_ref(rom_addr);

  // Reference: beat n of the sequence.
  function automatic int exp_addr(input int n);
    return (n / BPS) * 4 + ((n % BPS) % 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({tw_valid, tw_addr, tw_stage, tw_last_in_stage, tw_last, busy, done, rom_addr});
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_no_valid_yet", 32'(tw_valid), 32'd0);
  endtask

  // mode 0: ready=1; 1: stall 3 cycles at beat 10; 2: random ready;
  // 3: abort at beat 20; 4: start pulse mid-run and start during DONE.
  task automatic run(input int mode, output int beats);
    int n;
    int stalls;
    int last_x;
    bit got_done;
    bit post_stall_checked;
    logic [15:0] st3 [4];
    st3[0] = 16'h0100; st3[1] = 16'h00EC; st3[2] = 16'h00B5; st3[3] = 16'h0061;
    n = 0; stalls = 0; last_x = -10; got_done = 1'b0; post_stall_checked = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      case (mode)
        1:       bfly_ready = !(n == 9 && tw_valid && stalls < 3);
        2:       bfly_ready = 1'($urandom_range(0, 1));
        default: bfly_ready = 1'b1;
      endcase
      if (mode == 3 && n == 19 && tw_valid) begin
        abort = 1'b1;
        bfly_ready = 1'b0;
      end
      if (mode == 4 && n == 30) start = 1'b1;
      #1;
      if (c == 0) begin
        chk("first_valid", 32'(tw_valid), 32'd1);
        chk("first_addr", 32'(tw_addr), 32'd0);
      end
      if (abort) begin
        @(negedge clk);
        abort = 1'b0;
        bfly_ready = 1'b1;
        #1;
        chk("abort_valid", 32'(tw_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
          chk("abort_no_done", 32'(done), 32'd0);
          @(negedge clk);
          #1;
        end
        chk("abort_idle_busy", 32'(busy), 32'd0);
        beats = n;
        return;
      end
      if (mode == 1 && n == 9 && !bfly_ready) begin
        chk("stall_valid", 32'(tw_valid), 32'd1);
        chk("stall_tw_addr", 32'(tw_addr), 32'd5);
        chk("stall_rom_addr", 32'(rom_addr), 32'd5);
        chk("stall_data", 32'(rom_data), 32'h0000);
        stalls++;
      end
      if (mode == 1 && n == 10 && !post_stall_checked && tw_valid) begin
        chk("post_stall_addr", 32'(tw_addr), 32'd6);
        chk("stall_count", 32'(stalls), 32'd3);
        post_stall_checked = 1'b1;
      end
      if (tw_valid && !bfly_ready) chk("hold_rom_addr", 32'(rom_addr), 32'(tw_addr));
      if (tw_valid && bfly_ready) begin
        if (n >= TOT) begin
          chk("extra_beat", 32'(n), 32'(TOT - 1));
        end else begin
          chk("beat_addr", 32'(tw_addr), 32'(exp_addr(n)));
          chk("beat_stage", 32'(tw_stage), 32'(n / BPS));
          chk("beat_last_in_stage", 32'(tw_last_in_stage), 32'((n % BPS) == BPS - 1));
          chk("beat_last", 32'(tw_last), 32'(n == TOT - 1));
          chk("beat_data", 32'(rom_data), 32'(rom_ref(5'(exp_addr(n)))));
          chk("beat_busy", 32'(busy), 32'd1);
          if (n + 1 < TOT) chk("next_rom_addr", 32'(rom_addr), 32'(exp_addr(n + 1)));
          if (mode == 0 && n / BPS == 3) chk("stage3_data", 32'(rom_data), 32'(st3[n % 4]));
          if (n == TOT - 1) chk("last_data", 32'(rom_data), 32'h00FD);
        end
        n++;
        last_x = c;
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_timing", 32'(c), 32'(last_x + 1));
        chk("done_beats", 32'(n), 32'(TOT));
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(tw_valid), 32'd0);
        if (mode == 4) start = 1'b1;
      end
    end
    if (!got_done) chk("done_timeout", 32'(got_done), 32'd1);
    beats = n;
  endtask

  initial begin
    int beats;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    bfly_ready = 1'b1;
    #1;
    chk("reset_outputs", all_out(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_reset_idle", all_out(), 32'd0);
    end

    // Nominal run.
    do_start();
    run(0, beats);
    chk("nominal_beats", 32'(beats), 32'(TOT));

    // Stall at beat 10.
    do_start();
    run(1, beats);
    chk("stall_beats", 32'(beats), 32'(TOT));

    // Random back-pressure.
    for (int r = 0; r < 2; r++) begin
      do_start();
      run(2, beats);
      chk("random_beats", 32'(beats), 32'(TOT));
    end

    // Abort at beat 20, then a fresh run from address 0.
    do_start();
    run(3, beats);
    chk("abort_beats", 32'(beats), 32'd19);
    do_start();
    run(0, beats);
    chk("after_abort_beats", 32'(beats), 32'(TOT));

    // start during RUN and during DONE are ignored; next IDLE start runs again.
    do_start();
    run(4, beats);
    chk("ignored_start_beats", 32'(beats), 32'(TOT));
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("done_start_ignored_busy", 32'(busy), 32'd0);
    chk("done_start_ignored_valid", 32'(tw_valid), 32'd0);
    do_start();
    run(0, beats);
    chk("second_run_beats", 32'(beats), 32'(TOT));

    // Asynchronous reset mid-run.
    do_start();
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", all_out(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("midrun_reset_idle", all_out(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
